axi_arbiter: RTL and testbench

- Shares the single core AXI4 master port (io_master_*) between the IFU (read-only) and the LSU (read/write).
- Both requesters use a simple valid/ready request port with a one-cycle response pulse; exactly one transaction is outstanding at a time.

---
 rtl/axi_arbiter_if.sv | 75 +++++++
 rtl/axi_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_arbiter_if.sv
// axi_arbiter_if: signal bundle between the IFU/LSU requesters, the
// arbiter and the core AXI4 master port.
//   master modport : the arbiter's view (it drives req_ready, the response
//                    pulses and the io_master_* request channels).
//   slave modport  : the surrounding logic's view (requesters + AXI fabric).
// Request ports use valid/ready; responses are one-cycle pulses with read data
// on resp_rdata. io_master_* follows AXI4 with id/len/burst/size tied off.
interface axi_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_write;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_resp_valid;

    logic [31:0] resp_rdata;

    logic        io_master_arvalid;
    logic        io_master_arready;
    logic [31:0] io_master_araddr;
    logic        io_master_rvalid;
    logic        io_master_rready;
    logic [31:0] io_master_rdata;
    logic        io_master_awvalid;
    logic        io_master_awready;
    logic [31:0] io_master_awaddr;
    logic        io_master_wvalid;
    logic        io_master_wready;
    logic [31:0] io_master_wdata;
    logic [3:0]  io_master_wstrb;
    logic        io_master_bvalid;
    logic        io_master_bready;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid,
        input  lsu_req_valid, lsu_req_write, lsu_addr, lsu_wdata, lsu_wstrb,
        output lsu_req_ready, lsu_resp_valid,
        output resp_rdata,
        output io_master_arvalid, io_master_araddr,
        input  io_master_arready,
        input  io_master_rvalid, io_master_rdata,
        output io_master_rready,
        output io_master_awvalid, io_master_awaddr,
        input  io_master_awready,
        output io_master_wvalid, io_master_wdata, io_master_wstrb,
        input  io_master_wready,
        input  io_master_bvalid,
        output io_master_bready
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid,
        output lsu_req_valid, lsu_req_write, lsu_addr, lsu_wdata, lsu_wstrb,
        input  lsu_req_ready, lsu_resp_valid,
        input  resp_rdata,
        input  io_master_arvalid, io_master_araddr,
        output io_master_arready,
        output io_master_rvalid, io_master_rdata,
        input  io_master_rready,
        input  io_master_awvalid, io_master_awaddr,
        output io_master_awready,
        input  io_master_wvalid, io_master_wdata, io_master_wstrb,
        output io_master_wready,
        output io_master_bvalid,
        input  io_master_bready
    );
endinterface

// File: rtl/axi_arbiter.sv
// axi_arbiter: shares the single AXI4 master port between the IFU (reads only)
// and the LSU (reads and writes). One transaction is outstanding at a time.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - axi_arbiter_if.master: requester valid/ready ports, response
//           pulses, resp_rdata and the io_master_* AXI channels
// Parameters:
//   PRIO_LSU   - on simultaneous requests the LSU (1) or the IFU (0) wins
//   STARVE_MAX - consecutive contended wins after which the loser is forced in
module axi_arbiter #(
    parameter bit          PRIO_LSU   = 1'b1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    axi_arbiter_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

    state_t      state, state_nxt;
    logic [2:0]  starve_cnt;
    logic        owner_lsu;     // requester that owns the transaction in flight
    logic        loser_lsu;     // side that lost the most recent contended grant
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;

    logic        both_valid;
    logic        grant_lsu;
    logic        accept;

    assign both_valid = bus.ifu_req_valid && bus.lsu_req_valid;
    assign accept     = bus.ifu_req_ready || bus.lsu_req_ready;

    // Datapath outputs come straight from the latched fields; they only mean
    // something while the matching valid is high.
    assign bus.io_master_araddr = addr_q;
    assign bus.io_master_awaddr = addr_q;
    assign bus.io_master_wdata  = wdata_q;
    assign bus.io_master_wstrb  = wstrb_q;

    always_comb begin
        state_nxt             = state;
        grant_lsu             = 1'b0;
        bus.ifu_req_ready     = 1'b0;
        bus.lsu_req_ready     = 1'b0;
        bus.ifu_resp_valid    = 1'b0;
        bus.lsu_resp_valid    = 1'b0;
        bus.resp_rdata        = 32'h0;
        bus.io_master_arvalid = 1'b0;
        bus.io_master_rready  = 1'b0;
        bus.io_master_awvalid = 1'b0;
        bus.io_master_wvalid  = 1'b0;
        bus.io_master_bready  = 1'b0;

        case (state)
            IDLE: begin
                // Ready is gated by reset so that an asserted reset silences
                // the requesters even though IDLE decodes grants combinationally.
                if (reset) begin
                    if (both_valid) begin
                        if (starve_cnt == 3'(STARVE_MAX))
                            grant_lsu = !PRIO_LSU;
                        else
                            grant_lsu = PRIO_LSU;
                    end else begin
                        grant_lsu = bus.lsu_req_valid;
                    end
                    bus.ifu_req_ready = bus.ifu_req_valid && !grant_lsu;
                    bus.lsu_req_ready = bus.lsu_req_valid && grant_lsu;
                end
                if (bus.ifu_req_ready)
                    state_nxt = RD_AR;
                else if (bus.lsu_req_ready)
                    state_nxt = bus.lsu_req_write ? WR_AWW : RD_AR;
            end
            RD_AR: begin
                bus.io_master_arvalid = 1'b1;
                if (bus.io_master_arready)
                    state_nxt = RD_R;
            end
            RD_R: begin
                bus.io_master_rready = 1'b1;
                if (bus.io_master_rvalid) begin
                    bus.ifu_resp_valid = !owner_lsu;
                    bus.lsu_resp_valid = owner_lsu;
                    bus.resp_rdata     = bus.io_master_rdata;
                    state_nxt          = IDLE;
                end
            end
            WR_AWW: begin
                // AW and W complete independently, possibly in the same cycle.
                bus.io_master_awvalid = !aw_done;
                bus.io_master_wvalid  = !w_done;
                if ((aw_done || bus.io_master_awready) && (w_done || bus.io_master_wready))
                    state_nxt = WR_B;
            end
            WR_B: begin
                bus.io_master_bready = 1'b1;
                if (bus.io_master_bvalid) begin
                    bus.lsu_resp_valid = 1'b1;
                    state_nxt          = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            owner_lsu  <= 1'b0;
            loser_lsu  <= !PRIO_LSU;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner_lsu <= grant_lsu;
                addr_q    <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                wdata_q   <= bus.lsu_wdata;
                wstrb_q   <= bus.lsu_wstrb;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                if (both_valid) begin
                    // A win by the side that lost last time ends the streak.
                    if (grant_lsu == loser_lsu)
                        starve_cnt <= 3'd0;
                    else if (starve_cnt != 3'd7)
                        starve_cnt <= starve_cnt + 3'd1;
                    loser_lsu <= !grant_lsu;
                end else begin
                    starve_cnt <= 3'd0;
                end
            end
            if (state == WR_AWW) begin
                if (bus.io_master_awready && !aw_done)
                    aw_done <= 1'b1;
                if (bus.io_master_wready && !w_done)
                    w_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: self-checking bench for axi_arbiter. Expected responses are
// queued when a request is granted and popped when a response pulse appears.
module tb_axi_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;

    axi_arbiter_if bus();

    axi_arbiter #(.PRIO_LSU(1'b1), .STARVE_MAX(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          lsu;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [8:0] ctl_outs();
        return {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
                bus.io_master_arvalid, bus.io_master_rready, bus.io_master_awvalid,
                bus.io_master_wvalid, bus.io_master_bready};
    endfunction

    task automatic idle_inputs;
        bus.ifu_req_valid     = 1'b0;
        bus.ifu_addr          = 32'h0;
        bus.lsu_req_valid     = 1'b0;
        bus.lsu_req_write     = 1'b0;
        bus.lsu_addr          = 32'h0;
        bus.lsu_wdata         = 32'h0;
        bus.lsu_wstrb         = 4'h0;
        bus.io_master_arready = 1'b0;
        bus.io_master_rvalid  = 1'b0;
        bus.io_master_rdata   = 32'h0;
        bus.io_master_awready = 1'b0;
        bus.io_master_wready  = 1'b0;
        bus.io_master_bvalid  = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // AXI read slave stub: called the cycle after an accept. Holds arready low
    // for ar_wait cycles, then AR handshake, then rvalid the next cycle.
    task automatic serve_read(input int ar_wait, input logic [31:0] rdata,
                              output logic ifu_r, output logic lsu_r,
                              output logic [31:0] rd_obs, output logic [31:0] ar_obs);
        repeat (ar_wait) begin
            bus.io_master_arready = 1'b0;
            tick();
        end
        bus.io_master_arready = 1'b1;
        #1;
        ar_obs = bus.io_master_araddr;
        tick();
        bus.io_master_arready = 1'b0;
        bus.io_master_rvalid  = 1'b1;
        bus.io_master_rdata   = rdata;
        #1;
        ifu_r  = bus.ifu_resp_valid;
        lsu_r  = bus.lsu_resp_valid;
        rd_obs = bus.resp_rdata;
        tick();
        bus.io_master_rvalid = 1'b0;
        bus.io_master_rdata  = 32'h0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        tick();
        tick();
        n_tests++;
        if (ctl_outs() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", ctl_outs(), 9'b0);
        end
        n_tests++;
        if (bus.io_master_araddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want %h", bus.io_master_araddr, 32'h0);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release_grant: got %b want %b",
                     {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ifu_fetch;
        exp_t e;
        do_reset();
        // cycle T
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        #1;
        n_tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_ready: got %b want %b", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'h0010_0073});
        tick();
        // T+1
        bus.ifu_req_valid     = 1'b0;
        bus.io_master_arready = 1'b1;
        #1;
        n_tests++;
        if ({bus.io_master_arvalid, bus.io_master_araddr} !== {1'b1, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL fetch_ar: got %b/%h want 1/80000000", bus.io_master_arvalid, bus.io_master_araddr);
        end
        tick();
        // T+2
        bus.io_master_arready = 1'b0;
        #1;
        n_tests++;
        if ({bus.io_master_rready, bus.ifu_resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_wait_r: got %b want %b", {bus.io_master_rready, bus.ifu_resp_valid}, 2'b10);
        end
        tick();
        // T+3
        bus.io_master_rvalid = 1'b1;
        bus.io_master_rdata  = 32'h0010_0073;
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_sb: got empty queue want 1 entry");
        end else begin
            e = sb.pop_front();
            n_tests++;
            if ({bus.lsu_resp_valid, bus.ifu_resp_valid} !== {e.lsu, !e.lsu}) begin
                n_fail++;
                $display("FAIL fetch_resp: got lsu/ifu %b%b want %b%b",
                         bus.lsu_resp_valid, bus.ifu_resp_valid, e.lsu, !e.lsu);
            end
            n_tests++;
            if (bus.resp_rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL fetch_rdata: got %h want %h", bus.resp_rdata, e.rdata);
            end
        end
        tick();
        // T+4
        bus.io_master_rvalid = 1'b0;
        bus.ifu_req_valid    = 1'b1;
        #1;
        n_tests++;
        if (bus.ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_turnaround: got %b want 1", bus.ifu_req_ready);
        end
        bus.ifu_req_valid = 1'b0;
        #1;
    endtask

    task automatic test_contention;
        exp_t e;
        logic ifu_r, lsu_r;
        logic [31:0] rd, ar;
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_write = 1'b0;
        bus.lsu_addr      = 32'h0F00_0010;
        #1;
        n_tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL contend_grant: got %b want %b", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        end
        sb.push_back('{lsu: 1'b1, rdata: 32'hDEAD_0010});
        tick();
        bus.lsu_req_valid = 1'b0;
        serve_read(0, 32'hDEAD_0010, ifu_r, lsu_r, rd, ar);
        e = sb.pop_front();
        n_tests++;
        if ({lsu_r, ifu_r, rd, ar} !== {e.lsu, !e.lsu, e.rdata, 32'h0F00_0010}) begin
            n_fail++;
            $display("FAIL contend_lsu_resp: got %b%b %h %h want %b%b %h 0f000010",
                     lsu_r, ifu_r, rd, ar, e.lsu, !e.lsu, e.rdata);
        end
        // first IDLE cycle after the LSU response: IFU must be granted
        n_tests++;
        if (bus.ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL contend_ifu_next: got %b want 1", bus.ifu_req_ready);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'h1111_0000});
        tick();
        bus.ifu_req_valid = 1'b0;
        serve_read(0, 32'h1111_0000, ifu_r, lsu_r, rd, ar);
        e = sb.pop_front();
        n_tests++;
        if ({lsu_r, ifu_r, rd, ar} !== {e.lsu, !e.lsu, e.rdata, 32'h8000_0004}) begin
            n_fail++;
            $display("FAIL contend_ifu_resp: got %b%b %h %h want %b%b %h 80000004",
                     lsu_r, ifu_r, rd, ar, e.lsu, !e.lsu, e.rdata);
        end
    endtask

    task automatic test_starvation;
        exp_t e;
        logic ifu_r, lsu_r, exp_lsu;
        logic [31:0] rd, ar;
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0200;
        for (int g = 0; g < 5; g++) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_req_write = 1'b0;
            bus.lsu_addr      = 32'h0F00_0100 + 32'(g * 4);
            #1;
            exp_lsu = (g < 4);
            n_tests++;
            if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got %b want %b", g,
                         {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu});
            end
            sb.push_back('{lsu: exp_lsu, rdata: 32'h5A5A_0000 + 32'(g)});
            tick();
            bus.lsu_req_valid = 1'b0;
            if (!exp_lsu) bus.ifu_req_valid = 1'b0;
            serve_read(0, 32'h5A5A_0000 + 32'(g), ifu_r, lsu_r, rd, ar);
            e = sb.pop_front();
            n_tests++;
            if ({lsu_r, ifu_r, rd} !== {e.lsu, !e.lsu, e.rdata}) begin
                n_fail++;
                $display("FAIL starve_resp%0d: got %b%b %h want %b%b %h", g,
                         lsu_r, ifu_r, rd, e.lsu, !e.lsu, e.rdata);
            end
            if (g == 3) begin
                n_tests++;
                if (dut.starve_cnt !== 3'd4) begin
                    n_fail++;
                    $display("FAIL starve_cnt_max: got %0d want 4", dut.starve_cnt);
                end
            end
        end
        n_tests++;
        if (dut.starve_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_split_write;
        exp_t e;
        do_reset();
        // T
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_write = 1'b1;
        bus.lsu_addr      = 32'hA000_03F8;
        bus.lsu_wdata     = 32'h0000_0041;
        bus.lsu_wstrb     = 4'h1;
        #1;
        n_tests++;
        if (bus.lsu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_accept: got %b want 1", bus.lsu_req_ready);
        end
        sb.push_back('{lsu: 1'b1, rdata: 32'h0});
        tick();
        // T+1: wready only
        bus.lsu_req_valid    = 1'b0;
        bus.io_master_wready = 1'b1;
        #1;
        n_tests++;
        if ({bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready, bus.io_master_awaddr,
             bus.io_master_wdata, bus.io_master_wstrb} !== {3'b110, 32'hA000_03F8, 32'h41, 4'h1}) begin
            n_fail++;
            $display("FAIL wr_entry: got %b%b%b %h %h %h want 110 a00003f8 00000041 1",
                     bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready,
                     bus.io_master_awaddr, bus.io_master_wdata, bus.io_master_wstrb);
        end
        tick();
        bus.io_master_wready = 1'b0;
        // T+2, T+3: AW still pending, W finished
        for (int c = 2; c < 4; c++) begin
            #1;
            n_tests++;
            if ({bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready} !== 3'b100) begin
                n_fail++;
                $display("FAIL wr_aw_hold_t%0d: got %b want 100", c,
                         {bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready});
            end
            tick();
        end
        // T+4: awready
        bus.io_master_awready = 1'b1;
        #1;
        n_tests++;
        if ({bus.io_master_awvalid, bus.io_master_bready} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_aw_hs: got %b want 10", {bus.io_master_awvalid, bus.io_master_bready});
        end
        tick();
        // T+5
        bus.io_master_awready = 1'b0;
        #1;
        n_tests++;
        if ({bus.io_master_awvalid, bus.io_master_bready, bus.lsu_resp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL wr_b_wait: got %b want 010",
                     {bus.io_master_awvalid, bus.io_master_bready, bus.lsu_resp_valid});
        end
        tick();
        // T+6: bvalid
        bus.io_master_bvalid = 1'b1;
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.lsu_resp_valid, bus.ifu_resp_valid} !== {e.lsu, !e.lsu}) begin
            n_fail++;
            $display("FAIL wr_resp: got %b%b want %b%b", bus.lsu_resp_valid, bus.ifu_resp_valid, e.lsu, !e.lsu);
        end
        tick();
        bus.io_master_bvalid = 1'b0;
        // second store: AW and W accepted in the same cycle
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'hA000_0400;
        bus.lsu_wdata     = 32'h1234_5678;
        bus.lsu_wstrb     = 4'hF;
        tick();
        bus.lsu_req_valid     = 1'b0;
        bus.io_master_awready = 1'b1;
        bus.io_master_wready  = 1'b1;
        tick();
        bus.io_master_awready = 1'b0;
        bus.io_master_wready  = 1'b0;
        #1;
        n_tests++;
        if ({bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready} !== 3'b001) begin
            n_fail++;
            $display("FAIL wr_same_cycle: got %b want 001",
                     {bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready});
        end
        bus.io_master_bvalid = 1'b1;
        tick();
        bus.io_master_bvalid = 1'b0;
        #1;
    endtask

    task automatic test_ar_backpressure;
        exp_t e;
        logic ifu_r, lsu_r;
        logic [31:0] rd, ar;
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0100;
        sb.push_back('{lsu: 1'b0, rdata: 32'hCAFE_F00D});
        tick();
        bus.ifu_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if ({bus.io_master_arvalid, bus.io_master_araddr, bus.ifu_resp_valid, bus.lsu_resp_valid}
                !== {1'b1, 32'h8000_0100, 2'b00}) begin
                n_fail++;
                $display("FAIL ar_stall%0d: got %b %h %b%b want 1 80000100 00", c, bus.io_master_arvalid,
                         bus.io_master_araddr, bus.ifu_resp_valid, bus.lsu_resp_valid);
            end
            tick();
        end
        serve_read(0, 32'hCAFE_F00D, ifu_r, lsu_r, rd, ar);
        e = sb.pop_front();
        n_tests++;
        if ({lsu_r, ifu_r, rd, ar} !== {e.lsu, !e.lsu, e.rdata, 32'h8000_0100}) begin
            n_fail++;
            $display("FAIL ar_resp: got %b%b %h %h want %b%b %h 80000100", lsu_r, ifu_r, rd, ar,
                     e.lsu, !e.lsu, e.rdata);
        end
    endtask

    task automatic test_reset_mid_read;
        exp_t e;
        logic ifu_r, lsu_r;
        logic [31:0] rd, ar;
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0300;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_write = 1'b0;
        bus.lsu_addr      = 32'h0F00_0020;
        tick();
        bus.lsu_req_valid     = 1'b0;
        bus.io_master_arready = 1'b1;
        tick();
        bus.io_master_arready = 1'b0;
        #1;
        n_tests++;
        if ({bus.io_master_rready, dut.starve_cnt} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL rst_pre: got rready %b cnt %0d want 1 1", bus.io_master_rready, dut.starve_cnt);
        end
        bus.io_master_rvalid = 1'b1;
        bus.io_master_rdata  = 32'h0BAD_0BAD;
        reset = 1'b0;
        #1;
        n_tests++;
        if (ctl_outs() !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_async_outs: got %b want %b", ctl_outs(), 9'b0);
        end
        tick();
        reset = 1'b1;
        bus.io_master_rvalid = 1'b0;
        bus.io_master_rdata  = 32'h0;
        #1;
        n_tests++;
        if ({dut.starve_cnt, bus.ifu_req_ready, bus.io_master_rready} !== {3'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL rst_after: got cnt %0d ready %b rready %b want 0 1 0",
                     dut.starve_cnt, bus.ifu_req_ready, bus.io_master_rready);
        end
        sb.push_back('{lsu: 1'b0, rdata: 32'h0010_0073});
        tick();
        bus.ifu_req_valid = 1'b0;
        serve_read(0, 32'h0010_0073, ifu_r, lsu_r, rd, ar);
        e = sb.pop_front();
        n_tests++;
        if ({lsu_r, ifu_r, rd, ar} !== {e.lsu, !e.lsu, e.rdata, 32'h8000_0300}) begin
            n_fail++;
            $display("FAIL rst_fresh_fetch: got %b%b %h %h want %b%b %h 80000300", lsu_r, ifu_r, rd, ar,
                     e.lsu, !e.lsu, e.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_ifu_fetch();
        test_contention();
        test_starvation();
        test_split_write();
        test_ar_backpressure();
        test_reset_mid_read();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
